// File: rtl/reg_file_32x32_pkg.sv
// Shared widths and helpers for the 32x32 register file and its neighbours
// in the lab datapath (operand mux, datapath top).
package reg_file_32x32_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_ZERO   = 1;
    localparam int COUNT_W    = 8;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // Debug counters stick at their ceiling instead of wrapping back to zero.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == COUNT_MAX) ? value : value + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/reg_file_32x32_reg_en.sv
// One storage word: WIDTH-bit register with synchronous active-high reset
// and a load enable; reset wins over load.
module reg_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/reg_file_32x32.sv
// 32-entry general-purpose register file: two combinational read ports,
// one synchronous write port, optional hardwired r0 and optional write bypass.
module reg_file_32x32
    import reg_file_32x32_pkg::*;
#(
    parameter int WIDTH      = REG_WIDTH,
    parameter int DEPTH_LOG2 = REG_ADDR_W,
    parameter int ZERO_REG   = REG_ZERO,
    parameter int BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr_a,
    output logic [WIDTH-1:0]      rd_data_a,
    input  logic [DEPTH_LOG2-1:0] rd_addr_b,
    output logic [WIDTH-1:0]      rd_data_b,
    output logic [COUNT_W-1:0]    wr_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]   regs [DEPTH];
    logic [COUNT_W-1:0] count_reg;
    logic               wr_live;
    logic               hit_a;
    logic               hit_b;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_store
                logic load_en;
                assign load_en = wr_en && (wr_addr == DEPTH_LOG2'(gi));

                reg_en #(
                    .WIDTH(WIDTH)
                ) u_reg (
                    .clk  (clk),
                    .reset(reset),
                    .en   (load_en),
                    .d    (wr_data),
                    .q    (regs[gi])
                );
            end
        end
    endgenerate

    // A write that will actually land this edge: not squashed by reset and
    // not aimed at the hardwired zero register.
    assign wr_live = wr_en && !reset && !(ZERO_REG != 0 && wr_addr == '0);

    assign hit_a = (BYPASS != 0) && wr_live && (rd_addr_a == wr_addr);
    assign hit_b = (BYPASS != 0) && wr_live && (rd_addr_b == wr_addr);

    assign rd_data_a = hit_a ? wr_data : regs[rd_addr_a];
    assign rd_data_b = hit_b ? wr_data : regs[rd_addr_b];

    // Writes to r0 still count: the port accepted them even if storage ignores them.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (wr_en) begin
            count_reg <= sat_inc(count_reg);
        end
    end

    assign wr_count = count_reg;

endmodule
